// File: rtl/drum_seq_pkg.sv
// Shared types and constants for the drum step sequencer.
package drum_seq_pkg;

  typedef enum logic [1:0] {
    VOICE_KICK,
    VOICE_SNARE,
    VOICE_HAT,
    VOICE_TOM
  } voice_e;

  typedef enum logic {
    IDLE,
    RUN
  } seq_state_e;

  localparam int MCLK_PER_SAMPLE = 256;

endpackage

// File: rtl/seq_tick_divider.sv
// Two-stage divider: mclk -> sample ticks -> step ticks. step_tick is high on the
// mclk edge where the next step must fire; clr holds both counters at zero.
module seq_tick_divider #(
  parameter int MCLK_PER_SAMPLE = 256,
  parameter int PERIOD_BITS     = 16
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [PERIOD_BITS-1:0] step_period,
  output logic                   step_tick
);

  localparam int SW = $clog2(MCLK_PER_SAMPLE);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(MCLK_PER_SAMPLE - 1);

  logic [SW-1:0]          sample_cnt_reg;
  logic [PERIOD_BITS-1:0] step_cnt_reg;
  logic [PERIOD_BITS-1:0] period_last;
  logic                   sample_tick;
  logic                   step_last;

  // ">=" lets a period shortened mid-step terminate at the next comparison
  // instead of running the counter all the way around.
  always_comb begin
    period_last = (step_period == '0) ? '0 : step_period - PERIOD_BITS'(1);
    sample_tick = (sample_cnt_reg == SAMPLE_LAST);
    step_last   = (step_cnt_reg >= period_last);
    step_tick   = sample_tick && step_last;
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sample_cnt_reg <= '0;
      step_cnt_reg   <= '0;
    end else if (clr) begin
      sample_cnt_reg <= '0;
      step_cnt_reg   <= '0;
    end else begin
      sample_cnt_reg <= sample_tick ? '0 : sample_cnt_reg + SW'(1);
      if (sample_tick) begin
        step_cnt_reg <= step_last ? '0 : step_cnt_reg + PERIOD_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// Pattern-driven trigger source for the one-shot drum voices: fires one-mclk
// trigger pulses for every voice whose pattern bit is set on the current step.
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int NUM_VOICES      = 4,
  parameter int NUM_STEPS       = 16,
  parameter int MCLK_PER_SAMPLE = drum_seq_pkg::MCLK_PER_SAMPLE,
  parameter int PERIOD_BITS     = 16
) (
  input  logic                           mclk,
  input  logic                           rst,
  input  logic                           run,
  input  logic [PERIOD_BITS-1:0]         step_period,
  input  logic [$clog2(NUM_STEPS):0]     pat_len,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0]  wr_voice,
  input  logic [NUM_STEPS-1:0]           wr_mask,
  output logic [NUM_VOICES-1:0]          trig,
  output logic                           step_strobe,
  output logic [$clog2(NUM_STEPS)-1:0]   step_idx
);

  localparam int SB = $clog2(NUM_STEPS);
  localparam int LB = SB + 1;

  seq_state_e state_reg, state_next;

  logic [NUM_STEPS-1:0]  pattern_reg [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_reg;
  logic                  strobe_reg;
  logic [SB-1:0]         step_idx_reg;

  logic                  clr;
  logic                  step_tick;
  logic                  fire;
  logic [SB-1:0]         fire_idx;
  logic [SB-1:0]         adv_idx;
  logic [LB-1:0]         eff_len;
  logic [LB-1:0]         step_plus1;
  logic [NUM_VOICES-1:0] fire_trig;

  assign clr = (state_reg == IDLE) || !run;

  seq_tick_divider #(
    .MCLK_PER_SAMPLE (MCLK_PER_SAMPLE),
    .PERIOD_BITS     (PERIOD_BITS)
  ) u_div (
    .mclk        (mclk),
    .rst         (rst),
    .clr         (clr),
    .step_period (step_period),
    .step_tick   (step_tick)
  );

  // A step index already past a freshly shortened pattern wraps straight to 0.
  always_comb begin
    eff_len    = (pat_len == '0 || pat_len > LB'(NUM_STEPS)) ? LB'(NUM_STEPS) : pat_len;
    step_plus1 = {1'b0, step_idx_reg} + LB'(1);
    adv_idx    = (step_plus1 >= eff_len) ? '0 : step_plus1[SB-1:0];
  end

  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    fire_idx   = '0;
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next = RUN;
          fire       = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_next = IDLE;
        end else if (step_tick) begin
          fire     = 1'b1;
          fire_idx = adv_idx;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_fire
      assign fire_trig[gi] = pattern_reg[gi][fire_idx];
    end
  endgenerate

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      trig_reg     <= '0;
      strobe_reg   <= 1'b0;
      step_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (fire) begin
        trig_reg     <= fire_trig;
        strobe_reg   <= 1'b1;
        step_idx_reg <= fire_idx;
      end else begin
        trig_reg   <= '0;
        strobe_reg <= 1'b0;
        if (!run) begin
          step_idx_reg <= '0;
        end
      end
    end
  end

  // Fire reads pattern_reg on the same edge a write lands, so it sees the old row.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        pattern_reg[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_en && int'(wr_voice) == v) begin
          pattern_reg[v] <= wr_mask;
        end
      end
    end
  end

  assign trig        = trig_reg;
  assign step_strobe = strobe_reg;
  assign step_idx    = step_idx_reg;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer: directed scenarios plus randomized
// segments, compared every cycle against a countdown-based reference model.
module tb_drum_step_sequencer;
  import drum_seq_pkg::*;

  logic        mclk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] step_period;
  logic [4:0]  pat_len;
  logic        wr_en;
  logic [1:0]  wr_voice;
  logic [15:0] wr_mask;
  logic [3:0]  trig;
  logic        step_strobe;
  logic [3:0]  step_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state: running flag, mclk edges left until next fire, patterns.
  bit          m_running;
  int          m_cd;
  int          m_step;
  logic [3:0]  m_trig;
  logic        m_strobe;
  logic [15:0] m_pat [4];

  drum_step_sequencer dut (
    .mclk        (mclk),
    .rst         (rst),
    .run         (run),
    .step_period (step_period),
    .pat_len     (pat_len),
    .wr_en       (wr_en),
    .wr_voice    (wr_voice),
    .wr_mask     (wr_mask),
    .trig        (trig),
    .step_strobe (step_strobe),
    .step_idx    (step_idx)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_cd      = 0;
    m_step    = 0;
    m_trig    = '0;
    m_strobe  = 1'b0;
    for (int v = 0; v < 4; v++) m_pat[v] = '0;
  endtask

  task automatic model_fire(input int s);
    int p;
    for (int v = 0; v < 4; v++) m_trig[v] = m_pat[v][s];
    m_strobe = 1'b1;
    m_step   = s;
    p        = (step_period == 0) ? 1 : int'(step_period);
    m_cd     = p * 256;
    $display("fire t=%0t step=%0d trig=%b", $time, s, m_trig);
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_edge();
    int len;
    if (!rst) begin
      model_reset();
      return;
    end
    m_trig   = '0;
    m_strobe = 1'b0;
    len = (pat_len == 0 || pat_len > 16) ? 16 : int'(pat_len);
    if (!m_running) begin
      if (run) begin
        m_running = 1'b1;
        model_fire(0);
      end
    end else if (!run) begin
      m_running = 1'b0;
      m_step    = 0;
    end else begin
      m_cd--;
      if (m_cd == 0) model_fire((m_step + 1 >= len) ? 0 : m_step + 1);
    end
    if (wr_en && int'(wr_voice) < 4) m_pat[wr_voice] = wr_mask;
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge();
    #1;
    check("trig", 32'(trig), 32'(m_trig));
    check("strobe", 32'(step_strobe), 32'(m_strobe));
    check("step_idx", 32'(step_idx), 32'(m_step));
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_strobe && n < budget);
    check("strobe_within_budget", 32'(step_strobe), 32'd1);
  endtask

  task automatic write_row(input int v, input logic [15:0] mask);
    wr_en    = 1'b1;
    wr_voice = 2'(v);
    wr_mask  = mask;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int n, kick_cnt, snare_cnt, nxt, guard, seg_len;
    int exp_seq [5] = '{0, 1, 2, 0, 1};

    rst = 1'b0; run = 1'b1; wr_en = 1'b0; wr_voice = '0; wr_mask = '0;
    step_period = 16'd2; pat_len = 5'd16;
    model_reset();

    // Reset held with run=1: everything stays quiet, then step 0 fires on release.
    #1;
    check("reset_trig", 32'(trig), 32'd0);
    check("reset_idx", 32'(step_idx), 32'd0);
    check("reset_strobe", 32'(step_strobe), 32'd0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("release_strobe", 32'(step_strobe), 32'd1);
    check("release_idx", 32'(step_idx), 32'd0);

    // Kick 0x1111 / snare 0x0101 at two samples per step over one full pattern.
    run = 1'b0;
    tick();
    write_row(int'(VOICE_KICK), 16'h1111);
    write_row(int'(VOICE_SNARE), 16'h0101);
    run = 1'b1;
    kick_cnt = 0; snare_cnt = 0;
    for (int i = 0; i < 16 * 512; i++) begin
      tick();
      kick_cnt  += int'(trig[0]);
      snare_cnt += int'(trig[1]);
    end
    check("kick_pulses", 32'(kick_cnt), 32'd4);
    check("snare_pulses", 32'(snare_cnt), 32'd2);

    // Short pattern wrap, then shrinking pat_len while sitting on step 9.
    run = 1'b0;
    tick();
    for (int v = 0; v < 4; v++) write_row(v, 16'hFFFF);
    pat_len = 5'd3; step_period = 16'd1; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_strobe(600, n);
      check("len3_seq", 32'(step_idx), 32'(exp_seq[k]));
    end
    pat_len = 5'd16;
    guard = 0;
    do begin
      wait_strobe(600, n);
      guard++;
    end while (step_idx != 4'd9 && guard < 20);
    check("reached_step9", 32'(step_idx), 32'd9);
    pat_len = 5'd4;
    wait_strobe(600, n);
    check("shrink_wraps_to_0", 32'(step_idx), 32'd0);

    // Write landing on the exact fire edge: old row used now, new row next pass.
    run = 1'b0;
    tick();
    write_row(int'(VOICE_SNARE), 16'h0000);
    run = 1'b1;
    tick();
    guard = 0;
    while (m_cd != 1 && guard < 400) begin
      tick();
      guard++;
    end
    nxt = (m_step + 1 >= 4) ? 0 : m_step + 1;
    wr_en = 1'b1; wr_voice = 2'(VOICE_SNARE); wr_mask = 16'(1 << nxt);
    tick();
    wr_en = 1'b0;
    check("collide_strobe", 32'(step_strobe), 32'd1);
    check("collide_old_value", 32'(trig[1]), 32'd0);
    for (int k = 0; k < 4; k++) wait_strobe(600, n);
    check("collide_same_step", 32'(step_idx), 32'(nxt));
    check("collide_new_value", 32'(trig[1]), 32'd1);

    // Drop run mid-step, hold 10 cycles, raise: step 0 fires one cycle later.
    repeat (100) tick();
    run = 1'b0;
    repeat (10) tick();
    run = 1'b1;
    tick();
    check("restart_strobe", 32'(step_strobe), 32'd1);
    check("restart_idx", 32'(step_idx), 32'd0);

    // step_period 0 behaves as 1: 256 mclk between fires.
    for (int p = 0; p < 2; p++) begin
      run = 1'b0;
      tick();
      step_period = 16'(p);
      run = 1'b1;
      tick();
      wait_strobe(400, n);
      check("spacing_period_le1", 32'(n), 32'd256);
    end

    // Randomized segments: stop, choose rate/length, run with sporadic writes.
    for (int seg = 0; seg < 30; seg++) begin
      run = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
      step_period = 16'($urandom_range(0, 3));
      pat_len     = 5'($urandom_range(0, 31));
      run = 1'b1;
      seg_len = int'($urandom_range(300, 1500));
      for (int i = 0; i < seg_len; i++) begin
        wr_en    = ($urandom_range(0, 15) == 0);
        wr_voice = 2'($urandom);
        wr_mask  = 16'($urandom);
        if ($urandom_range(0, 299) == 0) pat_len = 5'($urandom_range(0, 31));
        tick();
      end
      wr_en = 1'b0;
    end

    // Asynchronous reset mid-run: outputs drop before the next edge, pattern cleared.
    run = 1'b1;
    repeat (50) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_trig", 32'(trig), 32'd0);
    check("async_strobe", 32'(step_strobe), 32'd0);
    check("async_idx", 32'(step_idx), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("post_reset_strobe", 32'(step_strobe), 32'd1);
    check("post_reset_pattern_clear", 32'(trig), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
